// File: rtl/pll_lock_rst_ctrl.sv
// pll_lock_rst_ctrl: PLL power-down / lock supervisor and fabric reset generator.
// Runs on the free-running PLL reference clock. It power-cycles the PLL, waits
// for a synchronised LOCK, qualifies it as stable and then releases an active-low
// reset for the PLL output clock domain. Lock timeouts trigger bounded retries,
// and lock losses while running are counted.
// Build option: define PLL_RST_AUTO_PWRDN_EN to make a lock loss in RUN perform a
// full PLL power cycle. When it is undefined, the controller only re-waits for lock.
module pll_lock_rst_ctrl #(
  parameter int SYNC_STAGES         = 2,
  parameter int PD_HOLD_CYCLES      = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_W               = 20
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PLL_LOCK,
  input  logic       RESTART,
  output logic       PLL_POWERDOWN_N,
  output logic       FABRIC_RST_N,
  output logic       READY,
  output logic       FAIL,
  output logic [7:0] LOSS_CNT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_PWRDN     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_QUALIFY   = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  // The retry counter must be able to reach MAX_RETRIES+1 without wrapping.
  localparam int RTY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 2);

  localparam logic [CNT_W-1:0] PD_LAST = CNT_W'(PD_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE  = CNT_W'(LOCK_STABLE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;      // shared hold / timeout cycle counter
  logic [CNT_W-1:0] stab_q, stab_d;    // consecutive synced-lock-high samples
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;

  logic pd_n_q, frst_n_q, ready_q, fail_q;

  logic             timeout;
  logic [RTY_W-1:0] retry_inc;
  logic             retry_exhausted;

  // Bring the asynchronous LOCK into the CLK domain through SYNC_STAGES flops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PLL_LOCK};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // The timeout fires on the cycle that would take the counter to LOCK_TIMEOUT_CYCLES.
  assign timeout         = (cnt_q >= TO_LAST);
  assign retry_inc       = (retry_q == {RTY_W{1'b1}}) ? retry_q : retry_q + 1'b1;
  assign retry_exhausted = (MAX_RETRIES != 0) && (int'(retry_inc) > MAX_RETRIES);

  // Next-state and counter logic. RESTART overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stab_d  = stab_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (RESTART) begin
      state_d = S_PWRDN;
      cnt_d   = '0;
      stab_d  = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_PWRDN: begin
          if (cnt_q >= PD_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_QUALIFY;
            stab_d  = CNT_W'(1);
            cnt_d   = cnt_q + 1'b1;
          end else if (timeout) begin
            state_d = retry_exhausted ? S_FAIL : S_PWRDN;
            retry_d = retry_inc;
            cnt_d   = '0;
            stab_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_QUALIFY: begin
          // Completed qualification wins over a timeout on the same edge.
          if (stab_q >= STABLE) begin
            state_d = S_RUN;
            cnt_d   = '0;
            stab_d  = '0;
            retry_d = '0;
          end else if (timeout) begin
            state_d = retry_exhausted ? S_FAIL : S_PWRDN;
            retry_d = retry_inc;
            cnt_d   = '0;
            stab_d  = '0;
          end else if (!lock_s) begin
            // The timeout window keeps running across a drop back to WAIT_LOCK.
            state_d = S_WAIT_LOCK;
            stab_d  = '0;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            stab_d = stab_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end

        S_RUN: begin
          if (!lock_s) begin
            loss_d = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
            cnt_d  = '0;
            stab_d = '0;
`ifdef PLL_RST_AUTO_PWRDN_EN
            state_d = S_PWRDN;
            retry_d = '0;
`else
            state_d = S_WAIT_LOCK;
`endif
          end
        end

        S_FAIL: begin
          state_d = S_FAIL;
        end

        default: begin
          state_d = S_PWRDN;
          cnt_d   = '0;
          stab_d  = '0;
        end
      endcase
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so they
  // change on the same edge as the state and never see the inputs combinationally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_PWRDN;
      cnt_q    <= '0;
      stab_q   <= '0;
      retry_q  <= '0;
      loss_q   <= '0;
      pd_n_q   <= 1'b0;
      frst_n_q <= 1'b0;
      ready_q  <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stab_q   <= stab_d;
      retry_q  <= retry_d;
      loss_q   <= loss_d;
      pd_n_q   <= (state_d == S_WAIT_LOCK) || (state_d == S_QUALIFY) || (state_d == S_RUN);
      frst_n_q <= (state_d == S_RUN);
      ready_q  <= (state_d == S_RUN);
      fail_q   <= (state_d == S_FAIL);
    end
  end

  assign PLL_POWERDOWN_N = pd_n_q;
  assign FABRIC_RST_N    = frst_n_q;
  assign READY           = ready_q;
  assign FAIL            = fail_q;
  assign LOSS_CNT        = loss_q;
  assign STATE           = state_q;

endmodule

// File: tb/tb_pll_lock_rst_ctrl.sv
// tb_pll_lock_rst_ctrl: directed and randomised checks of pll_lock_rst_ctrl.
// Expected timings are computed from the block's timing rules (hold length,
// synchroniser depth, stability length, timeout window and retry budget).
module tb_pll_lock_rst_ctrl;

  localparam int SYNC = 2;
  localparam int PD   = 8;
  localparam int TO   = 100;
  localparam int STB  = 16;
  localparam int MAXR = 2;
  // Edges from the LOCK sampling edge to reset release.
  localparam int REL  = SYNC + STB;
  // Steps observed until release: the first step already contains the sampling edge.
  localparam int REL_STEPS = REL + 1;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       PLL_LOCK = 1'b0;
  logic       RESTART = 1'b0;
  logic       PLL_POWERDOWN_N;
  logic       FABRIC_RST_N;
  logic       READY;
  logic       FAIL;
  logic [7:0] LOSS_CNT;
  logic [2:0] STATE;

  pll_lock_rst_ctrl #(
    .SYNC_STAGES        (SYNC),
    .PD_HOLD_CYCLES     (PD),
    .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES (STB),
    .MAX_RETRIES        (MAXR),
    .CNT_W              (20)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .PLL_LOCK       (PLL_LOCK),
    .RESTART        (RESTART),
    .PLL_POWERDOWN_N(PLL_POWERDOWN_N),
    .FABRIC_RST_N   (FABRIC_RST_N),
    .READY          (READY),
    .FAIL           (FAIL),
    .LOSS_CNT       (LOSS_CNT),
    .STATE          (STATE)
  );

  always #5 CLK = ~CLK;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] seq = 32'h0;
  logic [2:0]  last_st = 3'd0;
  int          exp_loss = 0;

  // Advance to the next falling edge and log any STATE change as a hex digit.
  task automatic step();
    @(negedge CLK);
    if (STATE !== last_st) begin
      seq     = {seq[27:0], 1'b0, STATE};
      last_st = STATE;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return PLL_POWERDOWN_N;
      1:       return READY;
      2:       return FABRIC_RST_N;
      default: return FAIL;
    endcase
  endfunction

  // Step until the selected output equals v; n = steps taken (== bound on expiry).
  task automatic wait_sig(input int w, input logic v, input int bound, output int n);
    n = 0;
    while (sel(w) !== v && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, output int n);
    n = 0;
    while (STATE !== s && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic restart_pulse();
    RESTART = 1'b1;
    step();
    RESTART = 1'b0;
    seq     = 32'h0;
    last_st = STATE;
  endtask

  // Reference rule: a lock raised d cycles into the WAIT_LOCK window reaches RUN
  // if release happens no later than the timeout edge.
  function automatic logic lock_wins(input int d);
    return (d + 1 + REL) <= TO;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d;
    int t_end;
    int rise_t[$];
    int fall_t[$];
    int fail_t;
    logic prev_pd;
    logic exp_run;

    // Reset state
    repeat (3) step();
    check("rst_state", STATE, 0);
    check("rst_pd_n", PLL_POWERDOWN_N, 0);
    check("rst_fabric", FABRIC_RST_N, 0);
    check("rst_ready", READY, 0);
    check("rst_fail", FAIL, 0);
    check("rst_loss", LOSS_CNT, 0);

    // Nominal bring-up
    RST_N   = 1'b1;
    seq     = 32'h0;
    last_st = STATE;
    wait_sig(0, 1'b1, 400, n);
    check("pd_rise", n, PD);
    check("wait_state", STATE, 1);
    repeat (20) step();
    PLL_LOCK = 1'b1;
    wait_sig(1, 1'b1, 400, n);
    check("ready_latency", n, REL_STEPS);
    check("bringup_seq", seq, 32'h123);
    check("bringup_fabric", FABRIC_RST_N, 1);
    check("bringup_pd_n", PLL_POWERDOWN_N, 1);

    // Lock loss in RUN
    repeat ($urandom_range(1, 5)) step();
    PLL_LOCK = 1'b0;
    wait_sig(2, 1'b0, 400, n);
    check("loss_latency_ok", (n >= 1) && (n <= SYNC + 1), 1);
    exp_loss++;
    check("loss_cnt", LOSS_CNT, exp_loss);
    check("loss_ready", READY, 0);
`ifdef PLL_RST_AUTO_PWRDN_EN
    check("loss_state", STATE, 0);
    check("loss_pd_low", PLL_POWERDOWN_N, 0);
    wait_sig(0, 1'b1, 400, n);
    check("loss_pd_pulse", n, PD);
`else
    check("loss_state", STATE, 1);
    check("loss_pd_high", PLL_POWERDOWN_N, 1);
    repeat (TO - 1) step();
    check("loss_wait_hold", STATE, 1);
    check("loss_wait_pd", PLL_POWERDOWN_N, 1);
    step();
    check("loss_timeout", STATE, 0);
`endif

    // Qualify chatter: 10 high, 3 low, then high
    restart_pulse();
    wait_sig(0, 1'b1, 400, n);
    check("chatter_pd_rise", n, PD);
    repeat (5) step();
    PLL_LOCK = 1'b1;
    repeat (10) step();
    PLL_LOCK = 1'b0;
    repeat (3) step();
    PLL_LOCK = 1'b1;
    wait_sig(1, 1'b1, 400, n);
    check("chatter_ready_latency", n, REL_STEPS);
    check("chatter_seq", seq, 32'h12123);

    // Lock arriving late in the timeout window (two boundary cases, then random)
    for (int t = 0; t < 6; t++) begin
      d = (t == 0) ? 81 : (t == 1) ? 82 : int'($urandom_range(60, 88));
      PLL_LOCK = 1'b0;
      restart_pulse();
      wait_sig(0, 1'b1, 400, n);
      check("trial_pd_rise", n, PD);
      repeat (d) step();
      PLL_LOCK = 1'b1;
      repeat (REL_STEPS) step();
      exp_run = lock_wins(d);
      $display("[TB] trial d=%0d expect_run=%0d ready=%0d state=%0d", d, exp_run, READY, STATE);
      check("trial_ready", READY, exp_run);
      check("trial_state", STATE, exp_run ? 3 : 0);
    end

    // Timeout and fail: lock held low for the whole retry budget
    PLL_LOCK = 1'b0;
    restart_pulse();
    prev_pd = PLL_POWERDOWN_N;
    fail_t  = -1;
    t_end   = (MAXR + 1) * (PD + TO) + 10;
    for (int t = 1; t <= t_end; t++) begin
      step();
      if (PLL_POWERDOWN_N !== prev_pd) begin
        if (PLL_POWERDOWN_N === 1'b1) rise_t.push_back(t);
        else fall_t.push_back(t);
        prev_pd = PLL_POWERDOWN_N;
      end
      if (FAIL === 1'b1 && fail_t < 0) fail_t = t;
    end
    check("to_rise_count", rise_t.size(), MAXR + 1);
    check("to_fall_count", fall_t.size(), MAXR + 1);
    for (int k = 0; k <= MAXR; k++) begin
      if (k < rise_t.size()) check("to_rise_time", rise_t[k], k * (PD + TO) + PD);
      if (k < fall_t.size()) check("to_fall_time", fall_t[k], (k + 1) * (PD + TO));
    end
    check("to_fail_time", fail_t, (MAXR + 1) * (PD + TO));
    check("fail_state", STATE, 4);
    check("fail_flag", FAIL, 1);
    check("fail_pd_n", PLL_POWERDOWN_N, 0);
    check("fail_fabric", FABRIC_RST_N, 0);
    check("fail_loss_kept", LOSS_CNT, exp_loss);
    restart_pulse();
    check("restart_fail_clr", FAIL, 0);
    check("restart_state", STATE, 0);

    // RESTART on the same edge as a lock loss
    wait_sig(0, 1'b1, 400, n);
    repeat (20) step();
    PLL_LOCK = 1'b1;
    wait_sig(1, 1'b1, 400, n);
    check("prio_bringup", n, REL_STEPS);
    PLL_LOCK = 1'b0;
    repeat (SYNC) step();
    restart_pulse();
    check("prio_state", STATE, 0);
    check("prio_loss", LOSS_CNT, exp_loss);
    check("prio_ready", READY, 0);

    // Loss counter saturation
    wait_sig(0, 1'b1, 400, n);
    check("sat_pd_rise", n, PD);
    for (int i = 0; i < 260; i++) begin
      PLL_LOCK = 1'b1;
      wait_sig(1, 1'b1, 400, n);
      repeat ($urandom_range(0, 3)) step();
      PLL_LOCK = 1'b0;
      wait_sig(1, 1'b0, 50, n);
      exp_loss = (exp_loss >= 255) ? 255 : exp_loss + 1;
      check("sat_loss", LOSS_CNT, exp_loss);
    end
    check("sat_final", LOSS_CNT, 255);

    // Reset asserted mid-QUALIFY acts before the next clock edge
    restart_pulse();
    wait_sig(0, 1'b1, 400, n);
    repeat (10) step();
    PLL_LOCK = 1'b1;
    wait_state(3'd2, 400, n);
    check("mq_reached_qualify", STATE, 2);
    repeat (4) step();
    #2 RST_N = 1'b0;
    #1;
    check("async_pd_n", PLL_POWERDOWN_N, 0);
    check("async_fabric", FABRIC_RST_N, 0);
    check("async_state", STATE, 0);
    check("async_loss", LOSS_CNT, 0);
    exp_loss = 0;
    PLL_LOCK = 1'b0;
    step();
    step();
    RST_N   = 1'b1;
    seq     = 32'h0;
    last_st = STATE;
    wait_sig(0, 1'b1, 400, n);
    check("rebringup_pd_rise", n, PD);
    repeat (20) step();
    PLL_LOCK = 1'b1;
    wait_sig(1, 1'b1, 400, n);
    check("rebringup_ready", n, REL_STEPS);
    check("rebringup_seq", seq, 32'h123);

    // Reset asserted in RUN drops the fabric reset immediately
    repeat (3) step();
    #2 RST_N = 1'b0;
    #1;
    check("async_run_fabric", FABRIC_RST_N, 0);
    check("async_run_ready", READY, 0);
    check("async_run_pd_n", PLL_POWERDOWN_N, 0);
    step();
    RST_N = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
